ram_bank_array: RTL and testbench
=================================

# ram_bank_array

Parametrised banked buffer RAM for the PCIe DMA inbound data path. It has one shared write port that is bank-decoded from the address and an independent read port per bank. It adds three behaviours: a per-entry valid bitmap with optional overwrite back-pressure, configurable registered read latency, and sticky out-of-range error reporting. It sits between the TLP receive engine (writer) and the per-channel DMA consumers (readers).

## Interface
- RAM_NUM, 8, number of banks; power of two, 2..16; BSEL_W = $clog2(RAM_NUM)
- DATA_W, 128, word width in bits
- ADDR_W, 8, entry address bits per bank; each bank holds 2^ADDR_W words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- CLR_ON_RD, 1, 1 = a read clears the entry's valid bit
- PROTECT, 1, 1 = a write to a valid entry is back-pressured
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- WrEn  in  1  write request
- WrAddr  in  32  [ADDR_W-1:0] entry, [ADDR_W+:BSEL_W] bank, upper bits must be 0
- WrData  in  DATA_W  write data
- WrRdy  out  1  write accepted when WrEn & WrRdy
- RdEn  in  RAM_NUM  per-bank read request
- RdAddr  in  RAM_NUM x 32  per-bank entry address; only [ADDR_W-1:0] is used
- RdData  out  RAM_NUM x DATA_W  read data
- RdVld  out  RAM_NUM  RdData/RdHit valid, one cycle per read
- RdHit  out  RAM_NUM  entry was valid when read
- AddrErr  out  1  sticky out-of-range write flag
- ErrClr  in  1  clears AddrErr

## Operation
- Write decode:
  - bank = WrAddr[ADDR_W +: BSEL_W], entry = WrAddr[ADDR_W-1:0].
  - OOR = |WrAddr[31:ADDR_W+BSEL_W].
- WrRdy is combinational. It is 0 only when PROTECT=1, the target entry is valid, and that bank is not reading the same entry with CLR_ON_RD=1 in the same cycle. Otherwise WrRdy is 1.
- An OOR write is always "accepted" (WrRdy=1), writes nothing, and sets AddrErr the next cycle.
- An accepted in-range write stores WrData and sets valid[bank][entry].
- Read:
  - RdEn[b] samples bank b at RdAddr[b][ADDR_W-1:0].
  - RdHit[b] returns the valid bit as it was before this cycle's update.
  - With CLR_ON_RD=1, the read clears the valid bit.
- Same-cycle write and read of the same bank/entry:
  - The read is read-first: it returns the old data and the old valid.
  - The valid bit ends set, because a write beats a clear.
- Reads in different banks are fully independent. The write port and any bank's read port operate concurrently.
- AddrErr: set on an OOR accept; cleared by ErrClr; set wins if both happen in the same cycle.
- Reset:
  - All valid bits are cleared.
  - RdData=0, RdVld=0, RdHit=0, AddrErr=0.
  - Memory contents are not reset.
  - Reads in flight when reset asserts are discarded: no RdVld after rst_n rises.

## Timing
- Write: data and the valid bit update at the clk edge where WrEn&WrRdy is sampled. A read issued on the next cycle sees the new data.
- Read: RdEn at edge N gives RdVld/RdData/RdHit at edge N+RD_LAT.
  - RD_LAT=2 adds an output register stage.
  - Back-to-back reads give one result per cycle.
- RdData holds its last value when RdVld=0.
- AddrErr asserts one cycle after the OOR write is accepted.

## Test plan
- Reset, then WrAddr=0x0000_0305, WrData=0xA5..A5, then RdEn[3] with RdAddr=5 -> after RD_LAT cycles: RdVld[3]=1, RdData[3]=0xA5..A5, RdHit[3]=1. A second read of the same entry gives RdHit[3]=0 (CLR_ON_RD=1).
- PROTECT=1, write 0x0102 twice without reading -> second cycle WrRdy=0, memory keeps the first data. Issue RdEn[1] RdAddr=2 in the same cycle as the retry -> WrRdy=1 and the write completes.
- Same-cycle write of 0x0410=X2 and read of bank 4 entry 0x10 that holds X1 -> read returns X1 with RdHit=1. The next read returns X2 with RdHit=1.
- WrAddr=0x0000_1000 (RAM_NUM=8) -> no bank written, AddrErr=1 next cycle. ErrClr asserted alongside a new OOR write -> AddrErr stays 1.
- All 8 banks read every cycle for 16 cycles while continuous writes run -> each RdVld pulses once per request, RD_LAT=1 and RD_LAT=2 both verified, no cross-bank corruption.
- Assert rst_n=0 with reads in flight -> all outputs 0 asynchronously. After release, RdVld stays 0 and every RdHit reads 0.

Source files
------------

// File: rtl/ram_bank_array.sv
// ram_bank_array: banked buffer RAM with one bank-decoded write port, per-bank read ports and a per-entry valid bitmap
// Ports: clk, rst_n (async active-low); WrEn/WrAddr/WrData/WrRdy write port, WrAddr = {zeros, bank, entry};
// RdEn/RdAddr per-bank read requests (32 address bits per bank, low ADDR_W used);
// RdData/RdVld/RdHit per-bank results RD_LAT cycles after RdEn; AddrErr sticky out-of-range flag, ErrClr clears it.
module ram_bank_array #(
  parameter int RAM_NUM   = 8,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int CLR_ON_RD = 1,
  parameter int PROTECT   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      WrEn,
  input  logic [31:0]               WrAddr,
  input  logic [DATA_W-1:0]         WrData,
  output logic                      WrRdy,
  input  logic [RAM_NUM-1:0]        RdEn,
  input  logic [RAM_NUM*32-1:0]     RdAddr,
  output logic [RAM_NUM*DATA_W-1:0] RdData,
  output logic [RAM_NUM-1:0]        RdVld,
  output logic [RAM_NUM-1:0]        RdHit,
  output logic                      AddrErr,
  input  logic                      ErrClr
);
  localparam int BSEL_W = $clog2(RAM_NUM);
  localparam int DEPTH  = 1 << ADDR_W;
  logic [DATA_W-1:0]         mem [RAM_NUM][DEPTH];
  logic [DEPTH-1:0]          vld [RAM_NUM];
  logic [ADDR_W-1:0]         ra  [RAM_NUM];
  logic [BSEL_W-1:0]         wb;
  logic [ADDR_W-1:0]         we;
  logic                      oor, clr_same, wr_acc;
  logic [RAM_NUM-1:0]        s1_vld, s1_hit;
  logic [RAM_NUM*DATA_W-1:0] s1_data;
  logic                      unused_rd_addr;
  assign unused_rd_addr = ^RdAddr;
  always_comb
    for (int b = 0; b < RAM_NUM; b++) ra[b] = RdAddr[b*32 +: ADDR_W];
  assign wb       = WrAddr[ADDR_W +: BSEL_W];
  assign we       = WrAddr[ADDR_W-1:0];
  assign oor      = |WrAddr[31:ADDR_W+BSEL_W];
  // a same-cycle clearing read of the target entry frees it, so the write need not stall
  assign clr_same = CLR_ON_RD != 0 && RdEn[wb] && ra[wb] == we;
  assign WrRdy    = oor || PROTECT == 0 || !vld[wb][we] || clr_same;
  assign wr_acc   = WrEn && WrRdy && !oor;
  always_ff @(posedge clk)
    if (wr_acc) mem[wb][we] <= WrData;
  // reads sample pre-edge state (read-first); the write's set is issued last so it beats the read's clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < RAM_NUM; b++) vld[b] <= '0;
      s1_vld  <= '0;
      s1_hit  <= '0;
      s1_data <= '0;
      AddrErr <= 1'b0;
    end else begin
      for (int b = 0; b < RAM_NUM; b++) begin
        s1_vld[b] <= RdEn[b];
        if (RdEn[b]) begin
          s1_hit[b] <= vld[b][ra[b]];
          s1_data[b*DATA_W +: DATA_W] <= mem[b][ra[b]];
          if (CLR_ON_RD != 0) vld[b][ra[b]] <= 1'b0;
        end
        if (wr_acc && wb == BSEL_W'(b)) vld[b][we] <= 1'b1;
      end
      AddrErr <= (WrEn && oor) || (AddrErr && !ErrClr);
    end
  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        RdVld  <= '0;
        RdHit  <= '0;
        RdData <= '0;
      end else begin
        RdVld <= s1_vld;
        for (int b = 0; b < RAM_NUM; b++)
          if (s1_vld[b]) begin
            RdHit[b] <= s1_hit[b];
            RdData[b*DATA_W +: DATA_W] <= s1_data[b*DATA_W +: DATA_W];
          end
      end
  end else begin : g_lat1
    assign RdVld  = s1_vld;
    assign RdHit  = s1_hit;
    assign RdData = s1_data;
  end
endmodule

// File: tb/tb_ram_bank_array.sv
// tb_ram_bank_array: checks RD_LAT=1 and RD_LAT=2 instances against a behavioural bank/valid model
module tb_ram_bank_array;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          WrEn = 1'b0, ErrClr = 1'b0;
  logic [31:0]   WrAddr = '0;
  logic [127:0]  WrData = '0;
  logic [7:0]    RdEn = '0;
  logic [255:0]  RdAddr = '0;
  logic          rdy1, rdy2, err1, err2;
  logic [7:0]    vld1, vld2, hit1, hit2;
  logic [1023:0] data1, data2;
  int            checks = 0, errors = 0;

  logic [127:0] mdata [8][256];
  bit           mvalid [8][256];
  logic [7:0]   exp1_vld, exp1_hit, exp2_vld, exp2_hit;
  logic [127:0] exp1_data [8];
  logic [127:0] exp2_data [8];
  logic         merr;

  typedef struct {
    bit wen; logic [31:0] waddr; logic [7:0] wbyte;
    bit ren; int rbank; logic [7:0] raddr; bit eclr;
    bit exp_rdy; bit exp_hit; logic [7:0] exp_byte; bit exp_err;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  ram_bank_array #(.RD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrRdy(rdy1), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(data1), .RdVld(vld1), .RdHit(hit1),
    .AddrErr(err1), .ErrClr(ErrClr));
  ram_bank_array #(.RD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrRdy(rdy2), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(data2), .RdVld(vld2), .RdHit(hit2),
    .AddrErr(err2), .ErrClr(ErrClr));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pf(int b, int e);
    return 8'(b * 31 + e * 7 + 3);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      for (int e = 0; e < 256; e++) mvalid[b][e] = 0;
      exp1_data[b] = '0;
      exp2_data[b] = '0;
    end
    exp1_vld = '0; exp1_hit = '0; exp2_vld = '0; exp2_hit = '0; merr = 0;
  endtask

  // one clock of the reference: write gated by occupancy, reads see pre-cycle contents
  task automatic model_step();
    logic [2:0] wbk;
    logic [7:0] went, a;
    bit oor, rdy;
    wbk = WrAddr[10:8];
    went = WrAddr[7:0];
    oor = WrAddr[31:11] != 0;
    rdy = oor || !mvalid[wbk][went] || (RdEn[wbk] && RdAddr[wbk*32 +: 8] == went);
    chk("wr_rdy_l1", 128'(rdy1), 128'(rdy));
    chk("wr_rdy_l2", 128'(rdy2), 128'(rdy));
    exp2_vld = exp1_vld;
    exp2_hit = exp1_hit;
    for (int b = 0; b < 8; b++) exp2_data[b] = exp1_data[b];
    exp1_vld = RdEn;
    for (int b = 0; b < 8; b++)
      if (RdEn[b]) begin
        a = RdAddr[b*32 +: 8];
        exp1_hit[b] = mvalid[b][a];
        exp1_data[b] = mdata[b][a];
        mvalid[b][a] = 0;
      end
    if (WrEn && !oor && rdy) begin
      mdata[wbk][went] = WrData;
      mvalid[wbk][went] = 1;
    end
    if (WrEn && oor) merr = 1;
    else if (ErrClr) merr = 0;
  endtask

  task automatic check_outs();
    chk("rd_vld_l1", 128'(vld1), 128'(exp1_vld));
    chk("rd_hit_l1", 128'(hit1 & exp1_vld), 128'(exp1_hit & exp1_vld));
    chk("rd_vld_l2", 128'(vld2), 128'(exp2_vld));
    chk("rd_hit_l2", 128'(hit2 & exp2_vld), 128'(exp2_hit & exp2_vld));
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("rd_data_l1_b%0d", b), data1[b*128 +: 128], exp1_data[b]);
      chk($sformatf("rd_data_l2_b%0d", b), data2[b*128 +: 128], exp2_data[b]);
    end
    chk("addr_err_l1", 128'(err1), 128'(merr));
    chk("addr_err_l2", 128'(err2), 128'(merr));
  endtask

  task automatic tick();
    #2;
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // asserts reset mid-cycle and checks outputs clear without a clock edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_vld_l1", 128'(vld1), 128'h0);
    chk("rst_vld_l2", 128'(vld2), 128'h0);
    chk("rst_hit_l1", 128'(hit1), 128'h0);
    chk("rst_hit_l2", 128'(hit2), 128'h0);
    chk("rst_err_l1", 128'(err1), 128'h0);
    chk("rst_err_l2", 128'(err2), 128'h0);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("rst_data_l1_b%0d", b), data1[b*128 +: 128], '0);
      chk($sformatf("rst_data_l2_b%0d", b), data2[b*128 +: 128], '0);
    end
    WrEn = 0; WrAddr = '0; WrData = '0; RdEn = '0; RdAddr = '0; ErrClr = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 32'h305,  8'hA5, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0};
    tbl[1]  = '{0, 32'h0,    8'h00, 1, 3, 8'h05, 0, 1, 1, 8'hA5, 0};
    tbl[2]  = '{0, 32'h0,    8'h00, 1, 3, 8'h05, 0, 1, 0, 8'hA5, 0};
    tbl[3]  = '{1, 32'h102,  8'h11, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0};
    tbl[4]  = '{1, 32'h102,  8'h22, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
    tbl[5]  = '{1, 32'h102,  8'h22, 1, 1, 8'h02, 0, 1, 1, 8'h11, 0};
    tbl[6]  = '{0, 32'h0,    8'h00, 1, 1, 8'h02, 0, 1, 1, 8'h22, 0};
    tbl[7]  = '{1, 32'h410,  8'h31, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0};
    tbl[8]  = '{1, 32'h410,  8'h32, 1, 4, 8'h10, 0, 1, 1, 8'h31, 0};
    tbl[9]  = '{0, 32'h0,    8'h00, 1, 4, 8'h10, 0, 1, 1, 8'h32, 0};
    tbl[10] = '{1, 32'h1000, 8'hFF, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1};
    tbl[11] = '{0, 32'h0,    8'h00, 1, 0, 8'h00, 0, 1, 0, pf(0, 0), 1};
    tbl[12] = '{1, 32'h1000, 8'hEE, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1};
    tbl[13] = '{0, 32'h0,    8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0};

    do_reset();
    for (int b = 0; b < 8; b++)
      for (int e = 0; e < 256; e++) begin
        WrEn = 1; WrAddr = 32'(b * 256 + e); WrData = {16{pf(b, e)}};
        tick();
      end
    WrEn = 0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      WrEn = tbl[i].wen; WrAddr = tbl[i].waddr; WrData = {16{tbl[i].wbyte}};
      ErrClr = tbl[i].eclr;
      RdEn = tbl[i].ren ? 8'(1 << tbl[i].rbank) : 8'h0;
      RdAddr = '0;
      RdAddr[tbl[i].rbank*32 +: 8] = tbl[i].raddr;
      #2;
      chk($sformatf("vec%0d_wr_rdy", i), 128'(rdy1), 128'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_addr_err", i), 128'(err1), 128'(tbl[i].exp_err));
      if (tbl[i].ren) begin
        chk($sformatf("vec%0d_rd_vld", i), 128'(vld1[tbl[i].rbank]), 128'h1);
        chk($sformatf("vec%0d_rd_hit", i), 128'(hit1[tbl[i].rbank]), 128'(tbl[i].exp_hit));
        chk($sformatf("vec%0d_rd_data", i), data1[tbl[i].rbank*128 +: 128], {16{tbl[i].exp_byte}});
      end
    end
    ErrClr = 0;

    for (int c = 0; c < 16; c++) begin
      WrEn = 1;
      WrAddr = {21'h0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 3))};
      WrData = {$urandom, $urandom, $urandom, $urandom};
      RdEn = 8'hFF;
      for (int b = 0; b < 8; b++) RdAddr[b*32 +: 32] = {$urandom_range(0, 3)};
      tick();
    end

    for (int c = 0; c < 1500; c++) begin
      WrEn = $urandom_range(0, 3) != 0;
      WrAddr = $urandom_range(0, 15) == 0 ? 32'h800 | (32'($urandom_range(1, 3)) << 11)
                                          : {21'h0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      WrData = {$urandom, $urandom, $urandom, $urandom};
      RdEn = 8'($urandom);
      for (int b = 0; b < 8; b++) RdAddr[b*32 +: 32] = {24'($urandom), 8'($urandom_range(0, 7))};
      ErrClr = $urandom_range(0, 7) == 0;
      tick();
    end

    WrEn = 0; ErrClr = 0; RdEn = 8'hFF;
    for (int b = 0; b < 8; b++) RdAddr[b*32 +: 32] = {$urandom_range(0, 7)};
    tick();
    do_reset();
    tick();
    tick();
    RdEn = 8'hFF;
    for (int b = 0; b < 8; b++) RdAddr[b*32 +: 32] = {$urandom_range(0, 7)};
    tick();
    chk("post_rst_vld_l1", 128'(vld1), 128'hFF);
    chk("post_rst_hit_l1", 128'(hit1), 128'h0);
    RdEn = 8'h0;
    tick();
    chk("post_rst_vld_l2", 128'(vld2), 128'hFF);
    chk("post_rst_hit_l2", 128'(hit2), 128'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
